// File: rtl/imem_loader_pkg.sv
// Shared types and sizes for the instruction memory and its runtime loader.
package imem_pkg;

  localparam int IMEM_ADDR_W = 8;
  localparam int IMEM_WORD_W = 32;
  localparam int IMEM_DEPTH  = 256;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WRITE,
    DONE,
    CHECK
  } loader_state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// MSB-first byte-to-word packer: shift register plus byte index.
module byte_packer
  import imem_pkg::*;
#(
  parameter int WORD_W         = IMEM_WORD_W,
  parameter int BYTES_PER_WORD = WORD_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word_out,
  output logic              last_byte
);

  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

  logic [IDX_W-1:0] idx;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx      <= '0;
      word_out <= '0;
    end else if (shift_en) begin
      idx      <= idx + IDX_W'(1);
      word_out <= (word_out << 8) | WORD_W'(byte_in);
    end
  end

  // High while the byte being offered would complete the word.
  assign last_byte = (idx == IDX_W'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/imem_loader.sv
// Runtime instruction-memory loader: packs host bytes into words and writes them from address 0.
// Optional trailing XOR checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int WORD_W = IMEM_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   word_count
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic              csum_err
`endif
);

  localparam int BYTES_PER_WORD = WORD_W / 8;

  loader_state_t     state;
  logic [ADDR_W:0]   len_q;
  logic [WORD_W-1:0] packed_word;
  logic [WORD_W-1:0] next_word;
  logic              last_byte;
  logic              accept;
  logic              start_ok;
  logic              pack_clr;
  logic              shift_en;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif

`ifdef IMEM_LOADER_CHECKSUM_EN
  assign byte_ready = (state == LOAD) || (state == CHECK);
`else
  assign byte_ready = (state == LOAD);
`endif
  assign busy      = (state == LOAD) || (state == WRITE);
  assign cpu_hold  = busy;
  assign accept    = byte_valid && byte_ready;
  assign start_ok  = start && ((state == IDLE) || (state == DONE));
  assign pack_clr  = start_ok || (state == WRITE);
  assign shift_en  = (state == LOAD) && accept;
  // The word including the byte accepted this cycle, so wr_data can be registered on the same edge.
  assign next_word = (packed_word << 8) | WORD_W'(byte_data);

  byte_packer #(
    .WORD_W         (WORD_W),
    .BYTES_PER_WORD (BYTES_PER_WORD)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (pack_clr),
    .shift_en  (shift_en),
    .byte_in   (byte_data),
    .word_out  (packed_word),
    .last_byte (last_byte)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      len_q      <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      done       <= 1'b0;
      word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum       <= '0;
      csum_err   <= 1'b0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            word_count <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum       <= '0;
            csum_err   <= 1'b0;
`endif
            if (len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              len_q <= len;
              done  <= 1'b0;
              state <= LOAD;
            end
          end
        end
        LOAD: begin
          if (accept) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum <= csum ^ byte_data;
`endif
            if (last_byte) begin
              state   <= WRITE;
              wr_en   <= 1'b1;
              wr_data <= next_word;
              wr_addr <= word_count[ADDR_W-1:0];
            end
          end
        end
        WRITE: begin
          // word_count is one bit wider than the address so a full-memory load ends at 2^ADDR_W.
          word_count <= word_count + (ADDR_W+1)'(1);
          if ((word_count + (ADDR_W+1)'(1)) == len_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state <= CHECK;
`else
            state <= DONE;
            done  <= 1'b1;
`endif
          end else begin
            state <= LOAD;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        CHECK: begin
          if (accept) begin
            csum_err <= (byte_data != csum);
            state    <= DONE;
            done     <= 1'b1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule
